// File: rtl/seg_memory.sv
`default_nettype none
// ============================================================================
// Module      : seg_memory
// Description : MIPS MEM stage - byte/half/word data memory, branch resolve,
//               MEM/WB pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_memory #(
  parameter int LEN        = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 9,
  parameter int NB_DEPTH   = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [LEN-1:0]        i_ALU_result,
  input  logic [LEN-1:0]        i_write_data,
  input  logic [NB_ADDR-1:0]    i_write_register,
  input  logic                  i_ALU_zero,
  input  logic [LEN-1:0]        i_PC_branch,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_DEPTH-1:0]   i_debug_addr,
  output logic [LEN-1:0]        o_debug_data,
  output logic                  o_PCSrc,
  output logic [LEN-1:0]        o_PC_branch,
  output logic [LEN-1:0]        o_read_data,
  output logic [LEN-1:0]        o_ALU_result,
  output logic [NB_ADDR-1:0]    o_write_register,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic                  o_misaligned
);

  localparam int DEPTH    = 1 << NB_DEPTH;
  localparam int NB_LANES = 4;

  logic [LEN-1:0] mem_q [DEPTH];

  logic                  read_data_q, misaligned_q_unused;
  logic [LEN-1:0]        read_data_d;
  logic [LEN-1:0]        rdata_q;
  logic [LEN-1:0]        alu_q;
  logic [NB_ADDR-1:0]    wreg_q;
  logic [NB_CTRL_WB-1:0] wb_q;
  logic                  misaligned_q;
  logic                  misaligned_d;

  logic                w_mem_read, w_mem_write, w_beq, w_bne, w_unsigned, w_jump;
  logic [1:0]          w_size;
  logic [1:0]          w_byte_off;
  logic                w_is_half, w_is_word;
  logic                w_bad_align;
  logic [NB_DEPTH-1:0] w_idx;
  logic [LEN-1:0]      w_old_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [LEN-1:0]      w_load_val;
  logic [LEN-1:0]      w_store_data;
  logic [NB_LANES-1:0] w_lane_sel;
  logic [NB_LANES-1:0] w_lane_we;
  logic                w_unused;

  assign w_mem_read  = i_ctrl_mem_bus[8];
  assign w_mem_write = i_ctrl_mem_bus[7];
  assign w_beq       = i_ctrl_mem_bus[6];
  assign w_bne       = i_ctrl_mem_bus[5];
  assign w_size      = i_ctrl_mem_bus[4:3];
  assign w_unsigned  = i_ctrl_mem_bus[2];
  assign w_jump      = i_ctrl_mem_bus[1];

  // Upper address bits are ignored on purpose: addresses wrap modulo depth.
  assign w_unused = ^{i_ALU_result[LEN-1:NB_DEPTH+2], i_ctrl_mem_bus[0],
                      read_data_q, misaligned_q_unused};
  assign read_data_q         = 1'b0;
  assign misaligned_q_unused = 1'b0;

  assign w_byte_off  = i_ALU_result[1:0];
  assign w_idx       = i_ALU_result[NB_DEPTH+1:2];
  assign w_is_half   = (w_size == 2'b01);
  assign w_is_word   = w_size[1];
  assign w_bad_align = (w_is_half & w_byte_off[0]) | (w_is_word & (w_byte_off != 2'b00));

  assign o_PCSrc      = w_jump | (w_beq & i_ALU_zero) | (w_bne & ~i_ALU_zero);
  assign o_PC_branch  = i_PC_branch;
  assign o_debug_data = mem_q[i_debug_addr];

  // Loads see the pre-edge contents, giving read-before-write on a combined access.
  assign w_old_word = mem_q[w_idx];
  assign w_byte     = w_old_word[{w_byte_off, 3'b000} +: 8];
  assign w_half     = w_old_word[{w_byte_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_val   = w_old_word;
    w_lane_sel   = {NB_LANES{1'b1}};
    w_store_data = i_write_data;
    case (w_size)
      2'b00: begin
        w_load_val   = {{(LEN-8){~w_unsigned & w_byte[7]}}, w_byte};
        w_lane_sel   = 4'b0001 << w_byte_off;
        w_store_data = {4{i_write_data[7:0]}};
      end
      2'b01: begin
        w_load_val   = {{(LEN-16){~w_unsigned & w_half[15]}}, w_half};
        w_lane_sel   = w_byte_off[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{i_write_data[15:0]}};
      end
      default: begin
        w_load_val   = w_old_word;
        w_lane_sel   = {NB_LANES{1'b1}};
        w_store_data = i_write_data;
      end
    endcase
  end

  assign w_lane_we    = w_lane_sel & {NB_LANES{w_mem_write & ~w_bad_align & i_enable & i_rst}};
  assign read_data_d  = (w_mem_read & ~w_bad_align) ? w_load_val : '0;
  assign misaligned_d = (w_mem_read | w_mem_write) & w_bad_align;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB_LANES; b++) begin
      if (w_lane_we[b]) begin
        mem_q[w_idx][8*b +: 8] <= w_store_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rdata_q      <= '0;
      alu_q        <= '0;
      wreg_q       <= '0;
      wb_q         <= '0;
      misaligned_q <= 1'b0;
    end else if (i_enable) begin
      rdata_q      <= read_data_d;
      alu_q        <= i_ALU_result;
      wreg_q       <= i_write_register;
      wb_q         <= i_ctrl_wb_bus;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_read_data      = rdata_q;
  assign o_ALU_result     = alu_q;
  assign o_write_register = wreg_q;
  assign o_ctrl_wb_bus    = wb_q;
  assign o_misaligned     = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_memory
// Description : Scoreboard bench for seg_memory with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_memory;

  localparam logic [8:0] C_IDLE = 9'h000;
  localparam logic [8:0] C_SW   = 9'h090;
  localparam logic [8:0] C_LW   = 9'h110;
  localparam logic [8:0] C_LB   = 9'h100;
  localparam logic [8:0] C_LBU  = 9'h104;
  localparam logic [8:0] C_LH   = 9'h108;
  localparam logic [8:0] C_SB   = 9'h080;
  localparam logic [8:0] C_SWLW = 9'h190;
  localparam logic [8:0] C_BEQ  = 9'h040;
  localparam logic [8:0] C_BNE  = 9'h020;
  localparam logic [8:0] C_JMP  = 9'h002;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_enable = 1'b1;
  logic [31:0] i_ALU_result = '0;
  logic [31:0] i_write_data = '0;
  logic [4:0]  i_write_register = '0;
  logic        i_ALU_zero = 1'b0;
  logic [31:0] i_PC_branch = '0;
  logic [1:0]  i_ctrl_wb_bus = '0;
  logic [8:0]  i_ctrl_mem_bus = '0;
  logic [6:0]  i_debug_addr = '0;
  logic [31:0] o_debug_data, o_PC_branch, o_read_data, o_ALU_result;
  logic        o_PCSrc, o_misaligned;
  logic [4:0]  o_write_register;
  logic [1:0]  o_ctrl_wb_bus;

  seg_memory dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_ALU_result(i_ALU_result), .i_write_data(i_write_data),
    .i_write_register(i_write_register), .i_ALU_zero(i_ALU_zero),
    .i_PC_branch(i_PC_branch), .i_ctrl_wb_bus(i_ctrl_wb_bus),
    .i_ctrl_mem_bus(i_ctrl_mem_bus), .i_debug_addr(i_debug_addr),
    .o_debug_data(o_debug_data), .o_PCSrc(o_PCSrc), .o_PC_branch(o_PC_branch),
    .o_read_data(o_read_data), .o_ALU_result(o_ALU_result),
    .o_write_register(o_write_register), .o_ctrl_wb_bus(o_ctrl_wb_bus),
    .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        mis;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [1:0]  wb;
  } exp_t;

  exp_t sb_q[$];
  logic tb_issue = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: a transaction issued before an edge shows up on the MEM/WB registers after it.
  initial begin
    forever begin
      logic v;
      exp_t e;
      @(posedge i_clk);
      v = tb_issue;
      #1;
      if (v) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty actual=output expected=none");
        end else begin
          e = sb_q.pop_front();
          if ({o_read_data, o_misaligned, o_ALU_result, o_write_register, o_ctrl_wb_bus} !==
              {e.rd, e.mis, e.alu, e.wreg, e.wb}) begin
            errors++;
            $display("FAIL %s actual rd=%h mis=%b alu=%h wr=%0d wb=%0d expected rd=%h mis=%b alu=%h wr=%0d wb=%0d",
                     e.name, o_read_data, o_misaligned, o_ALU_result, o_write_register,
                     o_ctrl_wb_bus, e.rd, e.mis, e.alu, e.wreg, e.wb);
          end
        end
      end
    end
  end

  task automatic drive(input string nm, input logic [8:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] wreg, input logic [1:0] wb,
                       input logic [31:0] exp_rd, input logic exp_mis);
    exp_t e;
    @(negedge i_clk);
    i_ctrl_mem_bus   = ctrl;
    i_ALU_result     = addr;
    i_write_data     = wd;
    i_write_register = wreg;
    i_ctrl_wb_bus    = wb;
    tb_issue         = 1'b1;
    e.name = nm; e.rd = exp_rd; e.mis = exp_mis; e.alu = addr; e.wreg = wreg; e.wb = wb;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge i_clk);
    tb_issue       = 1'b0;
    i_ctrl_mem_bus = C_IDLE;
  endtask

  task automatic check_dbg(input string nm, input logic [6:0] idx, input logic [31:0] exp);
    i_debug_addr = idx;
    #1;
    check32(nm, o_debug_data, exp);
  endtask

  task automatic branch(input string nm, input logic [8:0] ctrl, input logic z,
                        input logic [31:0] pc, input logic exp);
    @(negedge i_clk);
    tb_issue       = 1'b0;
    i_ctrl_mem_bus = ctrl;
    i_ALU_zero     = z;
    i_PC_branch    = pc;
    #1;
    check32(nm, {31'd0, o_PCSrc}, {31'd0, exp});
    check32({nm, "_pc"}, o_PC_branch, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with an idle bus
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check32("rst_rd",   o_read_data, 32'h0);
    check32("rst_alu",  o_ALU_result, 32'h0);
    check32("rst_wreg", {27'd0, o_write_register}, 32'h0);
    check32("rst_wb",   {30'd0, o_ctrl_wb_bus}, 32'h0);
    check32("rst_mis",  {31'd0, o_misaligned}, 32'h0);
    i_rst = 1'b1;

    // Word store, then load
    drive("sw_10", C_SW, 32'h10, 32'hDEADBEEF, 5'd1, 2'b01, 32'h0, 1'b0);
    drive("lw_10", C_LW, 32'h10, 32'h0, 5'd2, 2'b11, 32'hDEADBEEF, 1'b0);
    check_dbg("dbg_idx4", 7'd4, 32'hDEADBEEF);

    // Byte/half lanes
    drive("lb_13",  C_LB,  32'h13, 32'h0, 5'd3, 2'b10, 32'hFFFFFFDE, 1'b0);
    drive("lbu_13", C_LBU, 32'h13, 32'h0, 5'd4, 2'b10, 32'h000000DE, 1'b0);
    drive("lh_10",  C_LH,  32'h10, 32'h0, 5'd5, 2'b10, 32'hFFFFBEEF, 1'b0);
    drive("sb_11",  C_SB,  32'h11, 32'h00000055, 5'd6, 2'b00, 32'h0, 1'b0);
    drive("lw_sb",  C_LW,  32'h10, 32'h0, 5'd7, 2'b11, 32'hDEAD55EF, 1'b0);

    // Combined read/write returns the old word, the next load sees the new one
    drive("swlw_10", C_SWLW, 32'h10, 32'h12345678, 5'd8, 2'b01, 32'hDEAD55EF, 1'b0);
    drive("lw_new",  C_LW,   32'h10, 32'h0, 5'd9, 2'b01, 32'h12345678, 1'b0);

    // Misaligned accesses
    drive("sw_12_mis", C_SW, 32'h12, 32'hAAAAAAAA, 5'd10, 2'b01, 32'h0, 1'b1);
    drive("lw_after",  C_LW, 32'h10, 32'h0, 5'd11, 2'b01, 32'h12345678, 1'b0);
    drive("lh_11_mis", C_LH, 32'h11, 32'h0, 5'd12, 2'b01, 32'h0, 1'b1);
    drive("lb_11",     C_LB, 32'h11, 32'h0, 5'd13, 2'b01, 32'h00000056, 1'b0);
    check_dbg("dbg_mis_unchanged", 7'd4, 32'h12345678);

    // Branch resolution
    branch("beq_z1", C_BEQ, 1'b1, 32'h00000400, 1'b1);
    branch("beq_z0", C_BEQ, 1'b0, 32'h00000404, 1'b0);
    branch("bne_z0", C_BNE, 1'b0, 32'h00000408, 1'b1);
    branch("bne_z1", C_BNE, 1'b1, 32'h0000040C, 1'b0);
    branch("jmp_z0", C_JMP, 1'b0, 32'h00001000, 1'b1);
    branch("jmp_z1", C_JMP, 1'b1, 32'hFFFFFFFC, 1'b1);

    // Stall: the store is dropped and the registered outputs hold
    drive("sw_0",    C_SW, 32'h0, 32'h0, 5'd14, 2'b00, 32'h0, 1'b0);
    drive("lw_hold", C_LW, 32'h10, 32'h0, 5'd7, 2'b10, 32'h12345678, 1'b0);
    @(negedge i_clk);
    tb_issue       = 1'b0;
    i_enable       = 1'b0;
    i_ctrl_mem_bus = C_SW;
    i_ALU_result   = 32'h0;
    i_write_data   = 32'h1;
    i_write_register = 5'd30;
    i_ctrl_wb_bus  = 2'b01;
    @(negedge i_clk);
    check32("stall_rd",  o_read_data, 32'h12345678);
    check32("stall_alu", o_ALU_result, 32'h10);
    check32("stall_reg", {25'd0, o_write_register, o_ctrl_wb_bus, o_misaligned}, {25'd0, 5'd7, 2'b10, 1'b0});
    check_dbg("stall_nowrite", 7'd0, 32'h0);
    i_enable       = 1'b1;
    i_ctrl_mem_bus = C_IDLE;

    // Address wrap-around
    drive("sw_wrap", C_SW, 32'h00000204, 32'hCAFEF00D, 5'd15, 2'b01, 32'h0, 1'b0);
    drive("lw_4",    C_LW, 32'h4, 32'h0, 5'd16, 2'b01, 32'hCAFEF00D, 1'b0);
    check_dbg("dbg_wrap", 7'd1, 32'hCAFEF00D);

    // Reset during a store suppresses the write
    drive("sw_8", C_SW, 32'h8, 32'h22222222, 5'd17, 2'b01, 32'h0, 1'b0);
    @(negedge i_clk);
    tb_issue       = 1'b0;
    i_rst          = 1'b0;
    i_ctrl_mem_bus = C_SW;
    i_ALU_result   = 32'h8;
    i_write_data   = 32'h11111111;
    @(negedge i_clk);
    check_dbg("rst_nowrite", 7'd2, 32'h22222222);
    check32("rst2_alu", o_ALU_result, 32'h0);
    i_rst = 1'b1;
    idle();

    repeat (3) @(negedge i_clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
